// File: rtl/i2c_pkg.sv
// Shared encodings for the single-byte I2C master: FSM states, ACK levels and quarter-phase codes.
package i2c_pkg;
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_START_C  = 4'd1;
   localparam logic [3:0] ST_ADDR     = 4'd2;
   localparam logic [3:0] ST_ADDR_ACK = 4'd3;
   localparam logic [3:0] ST_WDATA    = 4'd4;
   localparam logic [3:0] ST_WACK     = 4'd5;
   localparam logic [3:0] ST_RDATA    = 4'd6;
   localparam logic [3:0] ST_RNACK    = 4'd7;
   localparam logic [3:0] ST_STOP_C   = 4'd8;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;
endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timing for one I2C bit slot: CLK_DIV prescaler feeding a 2-bit quarter counter.
// Held at q0 while clr is high; every register freezes while enb is low.
module i2c_phase_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enb,
   input  logic       clr,
   output logic [1:0] q,
   output logic       q_entry,
   output logic       slot_end
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          run;
   logic          q_last;

   assign run      = enb && !clr;
   assign q_last   = (cnt == CW'(CLK_DIV - 1));
   assign q_entry  = run && (cnt == '0);
   assign slot_end = run && q_last && (q == Q3);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         q   <= Q0;
      end else if (enb) begin
         if (clr) begin
            cnt <= '0;
            q   <= Q0;
         end else if (q_last) begin
            cnt <= '0;
            q   <= q + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte (write or read), STOP.
// SCL is decoded from state/quarter; SDA_O is registered at quarter entry so it always trails an SCL fall.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ENB,
   input  logic              START,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic              RW,
   input  logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] Q,
   output logic              Q_ready,
   output logic              BUSY,
   output logic              ACK_ERR,
   output logic              SCL,
   output logic              SDA_O,
   input  logic              SDA_I
);
   localparam int TX_W = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
   localparam int BC_W = (TX_W > 1) ? $clog2(TX_W) : 1;

   logic [3:0]        state;
   logic [1:0]        qph;
   logic              q_entry;
   logic              slot_end;
   logic [TX_W-1:0]   tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [BC_W-1:0]   bit_cnt;
   logic              rw_l;
   logic [DATA_W-1:0] d_l;
   logic              ack_bit;
   logic              sda_r;
   logic              addr_last;
   logic              data_last;

   i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
      .clk      (CLK),
      .reset    (RESET),
      .enb      (ENB),
      .clr      (state == ST_IDLE),
      .q        (qph),
      .q_entry  (q_entry),
      .slot_end (slot_end)
   );

   assign addr_last = (bit_cnt == BC_W'(ADDR_W));
   assign data_last = (bit_cnt == BC_W'(DATA_W - 1));
   assign SDA_O     = sda_r;

   always_comb begin
      SCL = 1'b1;
      case (state)
         ST_IDLE, ST_START_C: SCL = 1'b1;
         ST_STOP_C:           SCL = (qph != Q0);
         default:             SCL = (qph == Q2) || (qph == Q3);
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         BUSY    <= 1'b0;
         Q       <= '0;
         Q_ready <= 1'b0;
         ACK_ERR <= 1'b0;
         sda_r   <= 1'b1;
         tx_sr   <= '0;
         rx_sr   <= '0;
         bit_cnt <= '0;
         rw_l    <= 1'b0;
         d_l     <= '0;
         ack_bit <= I2C_ACK;
      end else if (ENB) begin
         Q_ready <= 1'b0;

         // SDA moves at q0 (data) or q2 (START/STOP edges while SCL is high); SDA_I sampled at q2 entry.
         if (q_entry) begin
            if (qph == Q0) begin
               case (state)
                  ST_ADDR, ST_WDATA: sda_r <= tx_sr[TX_W-1];
                  ST_STOP_C:         sda_r <= 1'b0;
                  default:           sda_r <= 1'b1;
               endcase
            end else if (qph == Q2) begin
               if (state == ST_START_C) sda_r <= 1'b0;
               if (state == ST_STOP_C)  sda_r <= 1'b1;
               if (state == ST_RDATA)   rx_sr <= {rx_sr[DATA_W-2:0], SDA_I};
               ack_bit <= SDA_I;
               if ((state == ST_ADDR_ACK || state == ST_WACK) && SDA_I == I2C_NACK)
                  ACK_ERR <= 1'b1;
            end
         end

         if (state == ST_IDLE) begin
            if (START) begin
               tx_sr   <= TX_W'({ADDR, RW}) << (TX_W - ADDR_W - 1);
               rw_l    <= RW;
               d_l     <= D;
               ACK_ERR <= 1'b0;
               BUSY    <= 1'b1;
               bit_cnt <= '0;
               state   <= ST_START_C;
            end
         end else if (slot_end) begin
            case (state)
               ST_START_C: state <= ST_ADDR;
               ST_ADDR: begin
                  tx_sr <= tx_sr << 1;
                  if (addr_last) begin
                     bit_cnt <= '0;
                     state   <= ST_ADDR_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_ADDR_ACK: begin
                  if (ack_bit == I2C_NACK) begin
                     state <= ST_STOP_C;
                  end else if (rw_l) begin
                     state <= ST_RDATA;
                  end else begin
                     tx_sr <= TX_W'(d_l) << (TX_W - DATA_W);
                     state <= ST_WDATA;
                  end
               end
               ST_WDATA: begin
                  tx_sr <= tx_sr << 1;
                  if (data_last) begin
                     bit_cnt <= '0;
                     state   <= ST_WACK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_WACK: state <= ST_STOP_C;
               ST_RDATA: begin
                  if (data_last) begin
                     bit_cnt <= '0;
                     Q       <= rx_sr;
                     Q_ready <= 1'b1;
                     state   <= ST_RNACK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_RNACK: state <= ST_STOP_C;
               default: begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural I2C slave on a wired-AND SDA line.
module tb_i2c_master;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENB = 1'b1;
   logic       START = 1'b0;
   logic [6:0] ADDR = '0;
   logic       RW = 1'b0;
   logic [7:0] D = '0;
   logic [7:0] Q;
   logic       Q_ready, BUSY, ACK_ERR, SCL, SDA_O;
   logic       sda_s = 1'b1;
   wire        sda = SDA_O & sda_s;

   i2c_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .START(START), .ADDR(ADDR), .RW(RW), .D(D),
      .Q(Q), .Q_ready(Q_ready), .BUSY(BUSY), .ACK_ERR(ACK_ERR), .SCL(SCL), .SDA_O(SDA_O),
      .SDA_I(sda)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave and bus monitor, evaluated mid-cycle.
   logic [6:0] sl_addr   = 7'h2A;
   logic [7:0] rd_byte   = 8'h3C;
   logic       sl_ack_en = 1'b1;
   logic       scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;
   logic       sl_act = 1'b0, sl_ack = 1'b0, sl_rw = 1'b0, last_bit = 1'b0;
   logic [7:0] sh = '0, addr_byte = '0, data_byte = '0, q_seen = '0;
   int         rise_cnt = 0, start_cnt = 0, stop_cnt = 0, dready_cnt = 0;
   int         busy_run = 0, qr_cnt = 0, qr_at = 0;

   always @(negedge CLK) begin
      if (BUSY) busy_run = busy_p ? busy_run + 1 : 1;
      busy_p = BUSY;
      if (Q_ready) begin
         qr_cnt++;
         qr_at  = busy_run;
         q_seen = Q;
      end
      if (scl_p && SCL && sda_p && !sda) begin
         start_cnt++;
         rise_cnt = 0;
         sl_act   = 1'b1;
         sl_ack   = 1'b0;
      end else if (scl_p && SCL && !sda_p && sda) begin
         stop_cnt++;
         sl_act = 1'b0;
         sda_s  = 1'b1;
      end else if (sl_act && !scl_p && SCL) begin
         sh = {sh[6:0], sda};
         rise_cnt++;
         if (rise_cnt == 18) last_bit = sda;
      end else if (sl_act && scl_p && !SCL) begin
         sda_s = 1'b1;
         if (rise_cnt == 8) begin
            addr_byte = sh;
            sl_rw     = sh[0];
            if (sl_ack_en && sh[7:1] == sl_addr) begin
               sl_ack = 1'b1;
               sda_s  = 1'b0;
            end
         end else if (sl_ack && sl_rw && rise_cnt >= 9 && rise_cnt <= 16) begin
            sda_s = rd_byte[16-rise_cnt];
         end else if (sl_ack && !sl_rw && rise_cnt == 17) begin
            data_byte = sh;
            dready_cnt++;
            sda_s = 1'b0;
         end
      end
      scl_p = SCL;
      sda_p = sda;
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
      cyc();
      ADDR = a; RW = r; D = d; START = 1'b1;
      cyc();
      START = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         if (!BUSY) break;
         cyc();
      end
      if (BUSY) chk("idle_timeout", BUSY, 1'b0);
   endtask

   task automatic wait_busy_run(input int n);
      for (int i = 0; i < 3000; i++) begin
         if (busy_run == n) break;
         cyc();
      end
      if (busy_run != n) chk("busy_run_timeout", busy_run, n);
   endtask

   int stop0, start0, dr0, qr0;

   task automatic snap();
      stop0 = stop_cnt; start0 = start_cnt; dr0 = dready_cnt; qr0 = qr_cnt;
   endtask

   initial begin
      repeat (3) cyc();
      chk("rst_scl", SCL, 1'b1);
      chk("rst_sda", SDA_O, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_q", Q, 8'h00);
      chk("rst_qready", Q_ready, 1'b0);
      chk("rst_ackerr", ACK_ERR, 1'b0);
      RESET = 1'b0;
      repeat (2) cyc();

      // 1: write 0x2A <- 0xA5, slave ACKs
      snap();
      start_txn(7'h2A, 1'b0, 8'hA5);
      wait_idle();
      chk("t1_addr", addr_byte, 8'h54);
      chk("t1_data", data_byte, 8'hA5);
      chk("t1_dready", dready_cnt - dr0, 1);
      chk("t1_ackerr", ACK_ERR, 1'b0);
      chk("t1_busy", busy_run, 320);
      chk("t1_qready", qr_cnt - qr0, 0);
      chk("t1_stop", stop_cnt - stop0, 1);
      chk("t1_rises", rise_cnt, 19);

      // 2: address NACK
      sl_ack_en = 1'b0;
      snap();
      start_txn(7'h2A, 1'b0, 8'hFF);
      wait_idle();
      chk("t2_ackerr", ACK_ERR, 1'b1);
      chk("t2_busy", busy_run, 176);
      chk("t2_rises", rise_cnt, 10);
      chk("t2_qready", qr_cnt - qr0, 0);
      chk("t2_stop", stop_cnt - stop0, 1);
      sl_ack_en = 1'b1;

      // 3: read 0x3C
      snap();
      start_txn(7'h2A, 1'b1, 8'h00);
      wait_idle();
      chk("t3_q", Q, 8'h3C);
      chk("t3_qseen", q_seen, 8'h3C);
      chk("t3_qready", qr_cnt - qr0, 1);
      chk("t3_qready_at", qr_at, 289);
      chk("t3_ackerr", ACK_ERR, 1'b0);
      chk("t3_busy", busy_run, 320);
      chk("t3_nack_bit", last_bit, 1'b1);
      chk("t3_stop", stop_cnt - stop0, 1);

      // 4: START while busy is ignored
      snap();
      start_txn(7'h2A, 1'b0, 8'hA5);
      wait_busy_run(50);
      ADDR = 7'h11; RW = 1'b1; D = 8'h00; START = 1'b1;
      cyc();
      START = 1'b0;
      wait_idle();
      chk("t4_addr", addr_byte, 8'h54);
      chk("t4_data", data_byte, 8'hA5);
      chk("t4_busy", busy_run, 320);
      chk("t4_stop", stop_cnt - stop0, 1);
      chk("t4_start", start_cnt - start0, 1);

      // 5: ENB low 40 cycles in address bit 2 (SCL high, SDA low)
      start_txn(7'h2A, 1'b0, 8'hC3);
      wait_busy_run(60);
      ENB = 1'b0;
      repeat (20) cyc();
      chk("t5_scl_frozen", SCL, 1'b1);
      chk("t5_sda_frozen", SDA_O, 1'b0);
      repeat (20) cyc();
      ENB = 1'b1;
      wait_idle();
      chk("t5_busy", busy_run, 360);
      chk("t5_addr", addr_byte, 8'h54);
      chk("t5_data", data_byte, 8'hC3);

      // 6: reset mid-write, then a fresh transaction
      start_txn(7'h2A, 1'b0, 8'hA5);
      wait_busy_run(100);
      RESET = 1'b1;
      cyc();
      RESET = 1'b0;
      chk("t6_scl", SCL, 1'b1);
      chk("t6_sda", SDA_O, 1'b1);
      chk("t6_busy", BUSY, 1'b0);
      chk("t6_ackerr", ACK_ERR, 1'b0);
      repeat (4) cyc();
      snap();
      start_txn(7'h2A, 1'b0, 8'h5A);
      wait_idle();
      chk("t6_busy_after", busy_run, 320);
      chk("t6_data_after", data_byte, 8'h5A);
      chk("t6_stop_after", stop_cnt - stop0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
